// File: rtl/jtcontra_cpu_cen.sv
// jtcontra_cpu_cen
// E/Q quadrature clock-enable generator for the Contra main 6809.
// A 3-bit phase counter advances once per 24 MHz clock, so an E period is
// normally 8 clocks. While a ROM fetch is pending at the E edge the counter
// is held, and each held clock is recorded as debt. Debt is then repaid by
// stepping the phase by 2, which gives a 4-clock E period until the debt is
// cleared. This keeps the average CPU rate at 3 MHz despite SDRAM latency.

module jtcontra_cpu_cen #(
  parameter int DEBTW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pause,
  input  logic             rom_cs,
  input  logic             rom_ok,
  output logic             cen_q,
  output logic             cen_e,
  output logic [DEBTW-1:0] debt
);

  localparam logic [DEBTW-1:0] DEBT_ZERO = {DEBTW{1'b0}};
  localparam logic [DEBTW-1:0] DEBT_MAX  = {DEBTW{1'b1}};
  localparam logic [DEBTW-1:0] DEBT_ONE  = {{(DEBTW-1){1'b0}}, 1'b1};

  logic [2:0]       p_r;
  logic [DEBTW-1:0] debt_r;
  logic             cen_e_r;
  logic             cen_q_r;

  logic             inc2_s;
  logic             edge_due_s;
  logic             q_due_s;
  logic             stall_s;
  logic [2:0]       p_next_s;
  logic [DEBTW-1:0] debt_up_s;

  // Step size, due conditions and stall request from the current state
  always_comb begin
    inc2_s     = 1'b0;
    edge_due_s = 1'b0;
    q_due_s    = 1'b0;
    stall_s    = 1'b0;
    p_next_s   = p_r;
    debt_up_s  = debt_r;

    inc2_s = (debt_r != DEBT_ZERO);

    // A step of 2 from phase 6 wraps just like a step of 1 from phase 7
    if (inc2_s) begin
      edge_due_s = (p_r == 3'd7) || (p_r == 3'd6);
      q_due_s    = (p_r == 3'd3) || (p_r == 3'd2);
      p_next_s   = p_r + 3'd2;
    end else begin
      edge_due_s = (p_r == 3'd7);
      q_due_s    = (p_r == 3'd3);
      p_next_s   = p_r + 3'd1;
    end

    // Only the E edge may be held; other phases run through a pending fetch
    stall_s = edge_due_s && rom_cs && !rom_ok;

    // Stall clocks past saturation are simply lost
    if (debt_r != DEBT_MAX) begin
      debt_up_s = debt_r + DEBT_ONE;
    end else begin
      debt_up_s = debt_r;
    end
  end

  // Phase counter, debt counter and registered enables
  always_ff @(posedge clk) begin
    if (rst) begin
      p_r     <= 3'd0;
      debt_r  <= DEBT_ZERO;
      cen_e_r <= 1'b0;
      cen_q_r <= 1'b0;
    end else if (pause) begin
      cen_e_r <= 1'b0;
      cen_q_r <= 1'b0;
    end else if (stall_s) begin
      debt_r  <= debt_up_s;
      cen_e_r <= 1'b0;
      cen_q_r <= 1'b0;
    end else begin
      p_r     <= p_next_s;
      cen_e_r <= edge_due_s;
      cen_q_r <= q_due_s;
      if (inc2_s) begin
        debt_r <= debt_r - DEBT_ONE;
      end else begin
        debt_r <= debt_r;
      end
    end
  end

  assign cen_e = cen_e_r;
  assign cen_q = cen_q_r;
  assign debt  = debt_r;

endmodule

// File: tb/tb_jtcontra_cpu_cen.sv
// tb_jtcontra_cpu_cen
// Table-driven bench for the Contra E/Q clock-enable generator. Each record
// holds the inputs applied before a rising edge and the outputs expected
// just after it. Edge numbers k in the fill loops count from 1 at the start
// of each scenario; every scenario begins with the phase counter at 0.

module tb_jtcontra_cpu_cen;

  logic       clk;
  logic       rst;
  logic       pause;
  logic       rom_cs;
  logic       rom_ok;
  logic       cen_q;
  logic       cen_e;
  logic [3:0] debt;

  int checks;
  int failures;

  jtcontra_cpu_cen #(.DEBTW(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .pause  (pause),
    .rom_cs (rom_cs),
    .rom_ok (rom_ok),
    .cen_q  (cen_q),
    .cen_e  (cen_e),
    .debt   (debt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         blk;
    logic       rst;
    logic       pause;
    logic       rom_cs;
    logic       rom_ok;
    logic       exp_e;
    logic       exp_q;
    logic [3:0] exp_debt;
  } vec_t;

  vec_t vecs[$];
  int   e_cnt[8];
  int   q_cnt[8];

  task automatic add(input int b, input logic r, input logic pa, input logic cs,
                     input logic ok, input logic e, input logic q, input int d);
    vec_t v;
    v.blk = b; v.rst = r; v.pause = pa; v.rom_cs = cs; v.rom_ok = ok;
    v.exp_e = e; v.exp_q = q; v.exp_debt = 4'(d);
    vecs.push_back(v);
  endtask

  task automatic check_bit(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%b required=%b", name, idx, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%0d required=%0d", name, idx, act, exp);
    end
  endtask

  // Hand-driven single clock used by the trailing sequence
  task automatic step(input logic pa, input string name, input logic e, input logic q, input int d);
    pause = pa; rom_cs = 1'b0; rom_ok = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    check_bit({name, "_cen_e"}, -1, cen_e, e);
    check_bit({name, "_cen_q"}, -1, cen_q, q);
    check_int({name, "_debt"}, -1, int'(debt), d);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; pause = 1'b0; rom_cs = 1'b0; rom_ok = 1'b0;
    for (int i = 0; i < 8; i++) begin e_cnt[i] = 0; q_cnt[i] = 0; end

    // Block 0: reset held for two clocks
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0);

    // Block 1: free run, Q after 4,12..60 and E after 8,16..64
    for (int k = 1; k <= 64; k++)
      add(1, 0, 0, 0, 0, (k % 8) == 0, (k % 8) == 4, 0);

    // Block 2: 5-clock stall at the first E edge, ROM ready on the sixth
    for (int k = 1; k <= 64; k++) begin
      int d;
      d = (k < 8) ? 0 : (k <= 12) ? k - 7 : (k <= 17) ? 17 - k : 0;
      add(2, 0, 0, (k >= 8 && k <= 13), (k == 13),
          (k == 13 || k == 17 || (k >= 24 && (k % 8) == 0)),
          (k == 4 || k == 15 || (k >= 20 && (k % 8) == 4)), d);
    end

    // Block 3: 20-clock stall saturates debt at 15, then 15 repay clocks
    for (int k = 1; k <= 45; k++) begin
      int d;
      d = (k < 8) ? 0 : (k <= 22) ? k - 7 : (k <= 27) ? 15 : (k <= 42) ? 42 - k : 0;
      add(3, 0, 0, (k >= 8 && k <= 27), 0,
          (k == 28 || k == 32 || k == 36 || k == 40 || k == 45),
          (k == 4 || k == 30 || k == 34 || k == 38 || k == 42), d);
    end

    // Block 4: ROM ready in the same clock as the E edge, no stall
    for (int k = 1; k <= 8; k++)
      add(4, 0, 0, 1, 1, k == 8, k == 4, 0);

    // Block 5: 7-clock stall, then a 2-clock stall while repaying debt 3
    for (int k = 1; k <= 32; k++) begin
      int d;
      d = (k < 8) ? 0 : (k <= 14) ? k - 7 : (k <= 18) ? 21 - k :
          (k == 19) ? 4 : (k == 20) ? 5 : (k <= 25) ? 25 - k : 0;
      add(5, 0, 0, ((k >= 8 && k <= 14) || k == 19 || k == 20), 0,
          (k == 15 || k == 21 || k == 25 || k == 32),
          (k == 4 || k == 17 || k == 23 || k == 28), d);
    end

    // Block 6: pause for 10 clocks while stalled with debt 4
    for (int k = 1; k <= 26; k++) begin
      int d;
      d = (k < 8) ? 0 : (k <= 11) ? k - 7 : (k <= 21) ? 4 : (k <= 25) ? 25 - k : 0;
      add(6, 0, (k >= 12 && k <= 21), (k >= 8 && k <= 21), 0,
          (k == 22 || k == 26), (k == 4 || k == 24), d);
    end

    // Block 7: reset while stalled with debt 3, then normal restart
    for (int k = 1; k <= 19; k++) begin
      int d;
      d = (k < 8) ? 0 : (k <= 10) ? k - 7 : 0;
      add(7, (k == 11), 0, (k >= 8 && k <= 11), 0, k == 19, (k == 4 || k == 15), d);
    end

    // Apply the table
    foreach (vecs[i]) begin
      rst = vecs[i].rst; pause = vecs[i].pause;
      rom_cs = vecs[i].rom_cs; rom_ok = vecs[i].rom_ok;
      @(posedge clk); #1;
      check_bit("cen_e", i, cen_e, vecs[i].exp_e);
      check_bit("cen_q", i, cen_q, vecs[i].exp_q);
      check_int("debt", i, int'(debt), int'(vecs[i].exp_debt));
      if (cen_e === 1'b1) e_cnt[vecs[i].blk]++;
      if (cen_q === 1'b1) q_cnt[vecs[i].blk]++;
    end

    check_int("free_run_e_count", 1, e_cnt[1], 8);
    check_int("free_run_q_count", 1, q_cnt[1], 8);
    check_int("stall_e_count", 2, e_cnt[2], 8);
    check_int("stall_q_count", 2, q_cnt[2], 8);

    // Pause at the Q phase: Q withheld while paused, issued on release
    step(1'b0, "pre_pause1", 1'b0, 1'b0, 0);
    step(1'b0, "pre_pause2", 1'b0, 1'b0, 0);
    step(1'b0, "pre_pause3", 1'b0, 1'b0, 0);
    for (int j = 0; j < 3; j++)
      step(1'b1, "paused", 1'b0, 1'b0, 0);
    step(1'b0, "release_q", 1'b0, 1'b1, 0);
    step(1'b0, "after_q", 1'b0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtcontra_cpu_cen.md
# jtcontra_cpu_cen

Clock-enable generator for the Contra main 6809. It derives the E/Q quadrature enables (3 MHz nominal) from the 24 MHz system clock and feeds `cpu_cen` to the main address decoder. It also stalls the CPU at the E edge while a ROM fetch is pending, and repays the lost clocks afterwards so average CPU speed stays at 3 MHz despite SDRAM latency.

## Interface

Parameters:
- `DEBTW`, default 4: width of the lost-cycle debt counter; saturates at 2^DEBTW-1.

Ports:
- `clk`, in, 1: 24 MHz system clock.
- `rst`, in, 1: synchronous, active-high reset.
- `pause`, in, 1: freezes the generator; no enables issued, no debt accrued.
- `rom_cs`, in, 1: main CPU ROM access in progress (from the main decoder).
- `rom_ok`, in, 1: ROM data valid (from the SDRAM controller).
- `cen_q`, out, 1: Q-phase enable, one-clock pulse.
- `cen_e`, out, 1: E-phase enable, one-clock pulse; drives the decoder `cpu_cen`.
- `debt`, out, DEBTW: current lost-cycle count, for observability.

## Operation

- Internal state:
  - 3-bit phase `p`, counts modulo 8.
  - DEBTW-bit `debt`.
- Step size `inc`:
  - 2 when `debt>0`.
  - 1 otherwise.
- Edge-due condition, evaluated on the current state: `p==7`, or `inc==2 && p==6`. Either means the step would wrap `p` past 7.
- Q-due condition: `p==3`, or `inc==2 && p==2`. Either means the step crosses from 3 into 4.
- `stall` = edge-due && `rom_cs` && !`rom_ok`.
- Per clock, in priority order:
  - `rst`: `p`=0, `debt`=0, `cen_e`=0, `cen_q`=0.
  - `pause`: `p` and `debt` hold; `cen_e`=0, `cen_q`=0.
  - `stall`:
    - `p` holds; `cen_e`=0, `cen_q`=0.
    - `debt` increments by 1, saturating at 2^DEBTW-1. Stall clocks beyond saturation are lost.
  - Otherwise:
    - `p` <= `p`+`inc` (mod 8).
    - `cen_e` <= edge-due; `cen_q` <= Q-due.
    - If `inc==2`, `debt` decrements by 1.
- Recovery:
  - Each repaid clock reclaims one 24 MHz clock.
  - During recovery the E period is 4 clocks.
  - Normal 8-clock period resumes once `debt` reaches 0. The change takes effect on the next step, even mid-period.
- The stall is evaluated only at the E edge. A pending ROM access at other phases does not hold `p`.
- `rom_cs` deasserting while stalled ends the stall on that clock; `p` advances normally.
- `rom_ok` high in the same clock as the edge-due condition: no stall.
- Stall and recovery may interleave: debt accrues during a stall even while `inc==2`.

## Timing

- All outputs are registered. Reset value of `cen_e`, `cen_q` and `debt` is 0.
- Counting edges from the first rising edge with `rst` low (edge 1), no stalls:
  - `cen_q` is high after edge 4, 12, 20…
  - `cen_e` is high after edge 8, 16, 24…
  - Each is exactly one clock wide.
- `cen_q` always leads `cen_e` by 4 clocks at the normal rate, and by 2 clocks during recovery.
- Stall latency:
  - `cen_e` is issued on the first edge at which `rom_ok` (or !`rom_cs`) is seen with `p` at the edge-due value.
  - `cen_e` is high the cycle after that edge.
- `debt` output reflects the register; it updates one clock after the stall or repay clock.
- `pause` takes effect on the edge where it is sampled. Release resumes from the held `p` with no catch-up.

## Test plan

- Free run: `rst` for 2 clocks, then idle with `rom_cs`=0 for 64 clocks.
  - Required: 8 `cen_e` pulses after edges 8, 16…64 and 8 `cen_q` pulses after edges 4, 12…60.
  - Required: `debt` stays 0.
- Single stall: `rom_cs`=1 with `rom_ok` low for 5 clocks starting when `p==7`.
  - Required: `cen_e` delayed 5 clocks and `debt` reaches 5.
  - Required: the next 5 steps use `inc=2` and `debt` returns to 0.
  - Required: the 2 E pulses after the stall are 4 clocks apart, then the period returns to 8.
  - Required: total enables over 64 clocks from reset still equal 8.
- Saturation: with DEBTW=4, stall for 20 clocks.
  - Required: `debt` holds at 15.
  - Required: afterwards exactly 15 repay clocks.
- Same-cycle ready: `rom_cs`=1 and `rom_ok`=1 at the edge-due clock.
  - Required: `cen_e` on schedule and `debt`=0.
- Stall during recovery: with `debt`=3, stall 2 clocks at `p==6` (`inc==2`).
  - Required: `debt` goes to 5, then decrements to 0.
- Pause and reset mid-stall:
  - `pause` asserted for 10 clocks while stalled with `debt`=4. Required: `debt` stays 4, no enables, and `p` is unchanged on release.
  - `rst` asserted while stalled. Required: `p`=0, `debt`=0, both enables 0 on the next clock.
